// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED PIO arbiter: FSM states and default
// PIO bus widths.
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_e;

  localparam int LED_AW = 2;
  localparam int LED_DW = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection. The search starts one past the last
// granted index, so a source that never drops its request cannot starve
// the others. The pointer only advances when the caller enables a grant.
module rr_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     en,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any_req
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] last_grant;
  logic [IW-1:0] cand;

  // Combinational search for the first requester after last_grant
  always_comb begin
    grant_idx = last_grant;
    any_req   = 1'b0;
    cand      = '0;
    for (int o = 1; o <= N_REQ; o++) begin
      cand = IW'((int'(last_grant) + o) % N_REQ);
      if (!any_req && req[cand]) begin
        any_req   = 1'b1;
        grant_idx = cand;
      end
    end
    grant = any_req ? (N_REQ'(1) << grant_idx) : '0;
  end

  // Pointer register: resets to the top index so requester 0 wins first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IW'(N_REQ - 1);
    end else if (en && any_req) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/led_pio_arbiter.sv
// Shares one LED PIO Avalon-MM slave between N_REQ req/ack requesters.
// Each grant produces exactly one single-cycle PIO access; the winner's
// command is latched in IDLE so later changes on its inputs are ignored.
module led_pio_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = LED_AW,
  parameter int DW    = LED_DW
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_wr,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       pio_address,
  output logic                pio_chipselect,
  output logic                pio_write_n,
  output logic [DW-1:0]       pio_writedata,
  input  logic [DW-1:0]       pio_readdata
);

  localparam int IW = $clog2(N_REQ);

  arb_state_e          state;
  logic [N_REQ-1:0]    grant;
  logic [IW-1:0]       grant_idx;
  logic                any_req;
  logic [N_REQ-1:0]    win_grant;
  logic                win_wr;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .en        (state == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Transaction FSM: latch winner in IDLE, strobe the PIO in ISSUE, ack in ACK
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ack            <= '0;
      rdata          <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= '0;
      pio_writedata  <= '0;
      win_grant      <= '0;
      win_wr         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (any_req) begin
            win_grant      <= grant;
            win_wr         <= req_wr[grant_idx];
            pio_address    <= req_addr[grant_idx*AW +: AW];
            pio_writedata  <= req_wdata[grant_idx*DW +: DW];
            pio_chipselect <= 1'b1;
            pio_write_n    <= ~req_wr[grant_idx];
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          // readdata is combinational from the slave while chipselect is high
          if (!win_wr) begin
            rdata <= pio_readdata;
          end
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          ack            <= win_grant;
          state          <= ACK;
        end
        ACK: begin
          ack   <= '0;
          state <= IDLE;
        end
        default: begin
          ack            <= '0;
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Bench for led_pio_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model. Includes a small LED PIO
// slave model (data register at address 0, other addresses read zero).
module tb_led_pio_arbiter;

  localparam int N  = 2;
  localparam int AW = 2;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req;
  logic [N-1:0]      req_wr;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      ack;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     pio_address;
  logic              pio_chipselect;
  logic              pio_write_n;
  logic [DW-1:0]     pio_writedata;
  logic [DW-1:0]     pio_readdata;

  logic [7:0]        led;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pio_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .ack            (ack),
    .rdata          (rdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata)
  );

  // LED PIO slave model
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) led <= 8'h00;
    else if (pio_chipselect && !pio_write_n && pio_address == 2'd0) led <= pio_writedata[7:0];
  end
  assign pio_readdata = (pio_address == 2'd0) ? {24'h0, led} : 32'h0;

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[i]          = wr;
    req_addr[i*AW+:AW] = a;
    req_wdata[i*DW+:DW] = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 2'b11;
    set_req(0, 1'b1, 2'd1, 32'h1111_1111);
    set_req(1, 1'b1, 2'd2, 32'h2222_2222);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ack !== 2'b00 || rdata !== 32'h0 || pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 ||
          pio_address !== 2'd0 || pio_writedata !== 32'h0) begin
        errors++;
        $display("FAIL reset_vals: ack=%b rdata=%h cs=%b wn=%b addr=%h wd=%h want 00/0/0/1/0/0",
                 ack, rdata, pio_chipselect, pio_write_n, pio_address, pio_writedata);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_address !== 2'd1 || pio_writedata !== 32'h1111_1111) begin
      errors++;
      $display("FAIL reset_first_grant: cs=%b addr=%h wd=%h want 1/1/11111111",
               pio_chipselect, pio_address, pio_writedata);
    end
    @(negedge clk);
    checks++;
    if (ack !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_ack: got %b want 01", ack);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    req = 2'b01;
    set_req(0, 1'b1, 2'd0, 32'h0000_00A5);
    @(negedge clk);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0 || pio_address !== 2'd0 ||
        pio_writedata !== 32'h0000_00A5 || ack !== 2'b00) begin
      errors++;
      $display("FAIL write_issue: cs=%b wn=%b addr=%h wd=%h ack=%b want 1/0/0/000000a5/00",
               pio_chipselect, pio_write_n, pio_address, pio_writedata, ack);
    end
    @(negedge clk);
    checks++;
    if (ack !== 2'b01 || pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) begin
      errors++;
      $display("FAIL write_ack: ack=%b cs=%b wn=%b want 01/0/1", ack, pio_chipselect, pio_write_n);
    end
    checks++;
    if (led !== 8'hA5) begin
      errors++;
      $display("FAIL write_led: got %h want a5", led);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    req = 2'b10;
    set_req(1, 1'b0, 2'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b1 || pio_address !== 2'd0) begin
      errors++;
      $display("FAIL read_issue: cs=%b wn=%b addr=%h want 1/1/0", pio_chipselect, pio_write_n, pio_address);
    end
    @(negedge clk);
    checks++;
    if (ack !== 2'b10 || rdata !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL read_addr0: ack=%b rdata=%h want 10/000000a5", ack, rdata);
    end
    req = '0;
    @(negedge clk);
    req = 2'b10;
    set_req(1, 1'b0, 2'd1, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (ack !== 2'b10 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL read_addr1: ack=%b rdata=%h want 10/00000000", ack, rdata);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic prev_cs;
    logic [N-1:0] exp_ack;
    do_reset();
    req = 2'b11;
    set_req(0, 1'b1, 2'd0, 32'h0000_0011);
    set_req(1, 1'b0, 2'd0, 32'h0);
    prev_cs = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_ack = (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++;
      if (ack !== exp_ack || pio_chipselect !== (c % 3 == 1)) begin
        errors++;
        $display("FAIL contention_c%0d: ack=%b cs=%b want %b/%b", c, ack, pio_chipselect, exp_ack, (c % 3 == 1));
      end
      checks++;
      if (prev_cs && pio_chipselect) begin
        errors++;
        $display("FAIL contention_b2b_cs_c%0d: got cs 1 twice want never", c);
      end
      prev_cs = pio_chipselect;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    do_reset();
    req = 2'b01;
    set_req(0, 1'b1, 2'd0, 32'h0000_003C);
    @(negedge clk);
    checks++;
    if (pio_chipselect !== 1'b1) begin
      errors++;
      $display("FAIL abort_issue: cs=%b want 1", pio_chipselect);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (ack !== 2'b01 || led !== 8'h3C) begin
      errors++;
      $display("FAIL abort_ack: ack=%b led=%h want 01/3c", ack, led);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 2'b10;
    set_req(1, 1'b1, 2'd3, 32'hCAFE_0001);
    @(negedge clk);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_address !== 2'd3) begin
      errors++;
      $display("FAIL midrst_issue: cs=%b addr=%h want 1/3", pio_chipselect, pio_address);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_address !== 2'd0 ||
        pio_writedata !== 32'h0 || ack !== 2'b00 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL midrst_async: cs=%b wn=%b addr=%h wd=%h ack=%b rdata=%h want 0/1/0/0/00/0",
               pio_chipselect, pio_write_n, pio_address, pio_writedata, ack, rdata);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ack !== 2'b00 || pio_chipselect !== 1'b0) begin
        errors++;
        $display("FAIL midrst_hold_c%0d: ack=%b cs=%b want 00/0", c, ack, pio_chipselect);
      end
    end
    req = '0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stability();
    do_reset();
    req = 2'b01;
    set_req(0, 1'b1, 2'd2, 32'hDEAD_BEEF);
    @(negedge clk);
    set_req(0, 1'b0, 2'd3, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if (ack !== 2'b01 || pio_writedata !== 32'hDEAD_BEEF || pio_address !== 2'd2) begin
      errors++;
      $display("FAIL stability: ack=%b wd=%h addr=%h want 01/deadbeef/2", ack, pio_writedata, pio_address);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_random(input int ncyc);
    int            last;
    int            busy;
    int            pick;
    logic [N-1:0]  m_onehot;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [7:0]    m_led;
    logic [DW-1:0] exp_rdata;
    logic          exp_cs;
    logic [N-1:0]  exp_ack;
    do_reset();
    last = N - 1; busy = 0; m_led = 8'h00; exp_rdata = '0;
    m_onehot = '0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      // what the previous rising edge should have done, given the inputs it saw
      exp_ack = '0;
      exp_cs  = 1'b0;
      if (busy == 2) begin
        busy    = 1;
        exp_ack = m_onehot;
        if (!m_wr) exp_rdata = (m_addr == 2'd0) ? {24'h0, m_led} : 32'h0;
        else if (m_addr == 2'd0) m_led = m_wdata[7:0];
      end else if (busy == 1) begin
        busy = 0;
      end else if (req != '0) begin
        pick = -1;
        for (int o = 1; o <= N; o++) begin
          if (pick < 0 && req[(last + o) % N]) pick = (last + o) % N;
        end
        last     = pick;
        busy     = 2;
        exp_cs   = 1'b1;
        m_onehot = '0;
        m_onehot[pick] = 1'b1;
        m_wr     = req_wr[pick];
        m_addr   = req_addr[pick*AW+:AW];
        m_wdata  = req_wdata[pick*DW+:DW];
      end
      checks++;
      if (ack !== exp_ack || pio_chipselect !== exp_cs) begin
        errors++;
        $display("FAIL rand_ctrl_c%0d: ack=%b cs=%b want %b/%b", c, ack, pio_chipselect, exp_ack, exp_cs);
      end
      checks++;
      if (rdata !== exp_rdata) begin
        errors++;
        $display("FAIL rand_rdata_c%0d: got %h want %h", c, rdata, exp_rdata);
      end
      if (exp_cs) begin
        checks++;
        if (pio_write_n !== ~m_wr || pio_address !== m_addr || pio_writedata !== m_wdata) begin
          errors++;
          $display("FAIL rand_cmd_c%0d: wn=%b addr=%h wd=%h want %b/%h/%h",
                   c, pio_write_n, pio_address, pio_writedata, ~m_wr, m_addr, m_wdata);
        end
      end else begin
        checks++;
        if (pio_write_n !== 1'b1) begin
          errors++;
          $display("FAIL rand_wn_idle_c%0d: got %b want 1", c, pio_write_n);
        end
      end
      // requesters: hold until ack, then drop or issue a fresh command
      for (int i = 0; i < N; i++) begin
        if (exp_ack[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else set_req(i, 1'($urandom_range(1, 0)),
                       ($urandom_range(1, 0) == 1) ? 2'd0 : AW'($urandom_range(3, 1)), $urandom);
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          set_req(i, 1'($urandom_range(1, 0)),
                  ($urandom_range(1, 0) == 1) ? 2'd0 : AW'($urandom_range(3, 1)), $urandom);
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_abort();
    test_mid_reset();
    test_stability();
    test_random(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
